// File: rtl/program_loader.sv
// program_loader: boot-time image loader for the single-cycle core.
// Accepts a framed byte stream (16-bit big-endian word count, 4*N data
// bytes, one XOR checksum byte), assembles big-endian 32-bit words, writes
// them sequentially into instruction memory and keeps the core in reset
// until a complete image with a matching checksum has been written.
// ADDR_WIDTH is expected to be in the range 1..15 so that the largest legal
// word count (2^ADDR_WIDTH) still fits in the 16-bit header field.
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Largest legal word count; anything above it cannot fit in imem.
    localparam logic [16:0]         MAX_WORDS = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;

    logic [7:0]            n_hi;       // high byte of the word count
    logic [ADDR_WIDTH:0]   n_words;    // word count, one bit wider than the address
    logic [ADDR_WIDTH:0]   word_cnt;   // words issued so far; wide so N=2^ADDR_WIDTH never wraps
    logic [1:0]            byte_cnt;   // byte position inside the current word
    logic [23:0]           word_buf;   // first three bytes of the word being assembled
    logic [7:0]            csum;       // running XOR over data bytes only

    logic                  accept;
    logic [15:0]           hdr_n;
    logic                  oversize;
    logic                  last_byte;
    logic                  last_word;

    // Handshake: only the four receiving states take bytes, never during reset.
    assign rx_ready = !reset && (state inside {HDR_HI, HDR_LO, DATA, CHECK});
    assign accept   = rx_valid && rx_ready;

    // Full word count as it becomes known while N_LO is on the bus.
    assign hdr_n    = {n_hi, rx_data};
    assign oversize = {1'b0, hdr_n} > MAX_WORDS;

    // Word-completion and frame-completion decodes for the DATA state.
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = ((word_cnt + CNT_ONE) == n_words);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the status outputs that follow the state.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            HDR_HI: begin
                if (accept) begin
                    state_next = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (oversize) begin
                        state_next = ERROR;
                    end else if (hdr_n == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && last_byte && last_word) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_next = (rx_data == csum) ? DONE : ERROR;
                end
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_next = HDR_HI;
            end
        endcase
    end

    // Header capture, word assembly, checksum and the registered imem write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_hi       <= 8'd0;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'd0;
            csum       <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            // The write strobe is a one-cycle pulse; address and data hold.
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_HI: begin
                        n_hi <= rx_data;
                    end
                    HDR_LO: begin
                        // Truncation only matters for oversize counts, which go to ERROR.
                        n_words <= hdr_n[ADDR_WIDTH:0];
                    end
                    DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            imem_wdata <= {word_buf, rx_data};
                            word_cnt   <= word_cnt + CNT_ONE;
                        end else begin
                            word_buf <= {word_buf[15:0], rx_data};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: nominal load, checksum errors,
// empty and oversize images, full-capacity image, stalled source and
// reset in the middle of a frame.
module tb_program_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0]   wr_data_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    frame_q[$];

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Record every imem write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_data_q.push_back(imem_wdata);
            wr_addr_q.push_back(imem_addr);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_data_q.delete();
        wr_addr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input int max_gap);
        foreach (frame_q[i]) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(frame_q[i]);
        end
    endtask

    task automatic set_nominal(input logic [7:0] cs);
        frame_q = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'hAC, 8'h08, 8'h00, 8'h00, cs};
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", imem_we); end
        vectors++;
        if (imem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        vectors++;
        if (imem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
        vectors++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got cpu_reset=%b done=%b error=%b want 1 0 0", cpu_reset, done, error);
        end
        vectors++;
        if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        vectors++;
        if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", rx_ready); end
    endtask

    task automatic test_nominal();
        apply_reset();
        set_nominal(8'h89);
        for (int i = 0; i < 11; i++) begin
            send_byte(frame_q[i]);
            if (i == 1) begin
                vectors++;
                if (imem_we !== 1'b0) begin miscompares++; $display("FAIL nom_hdr_no_write: got %b want 0", imem_we); end
            end
            if (i == 5) begin
                vectors++;
                if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h20080005) begin
                    miscompares++;
                    $display("FAIL nom_word0: got we=%b @%h %h want 1 @00 20080005", imem_we, imem_addr, imem_wdata);
                end
            end
            if (i == 6) begin
                vectors++;
                if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h20080005) begin
                    miscompares++;
                    $display("FAIL nom_hold: got we=%b @%h %h want 0 @00 20080005", imem_we, imem_addr, imem_wdata);
                end
            end
            if (i == 9) begin
                vectors++;
                if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 32'hAC080000) begin
                    miscompares++;
                    $display("FAIL nom_word1: got we=%b @%h %h want 1 @01 AC080000", imem_we, imem_addr, imem_wdata);
                end
                vectors++;
                if (cpu_reset !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL nom_before_csum: got cpu_reset=%b done=%b want 1 0", cpu_reset, done);
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || rx_ready !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_done: got done=%b cpu_reset=%b rx_ready=%b error=%b want 1 0 0 0",
                     done, cpu_reset, rx_ready, error);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        vectors++;
        if (wr_data_q.size() !== 2 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL nom_after: got writes=%0d done=%b want 2 1", wr_data_q.size(), done);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        set_nominal(8'h88);
        send_frame(0);
        vectors++;
        if (wr_data_q.size() !== 2) begin
            miscompares++;
            $display("FAIL bad_writes: got %0d want 2", wr_data_q.size());
        end else begin
            vectors++;
            if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h20080005 ||
                wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'hAC080000) begin
                miscompares++;
                $display("FAIL bad_write_vals: got @%h %h @%h %h want @00 20080005 @01 AC080000",
                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
        vectors++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_status: got error=%b done=%b cpu_reset=%b want 1 0 1", error, done, cpu_reset);
        end
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(i * 37);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        vectors++;
        if (rx_ready !== 1'b0 || wr_data_q.size() !== 2 || error !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ignored: got ready=%b writes=%0d error=%b done=%b want 0 2 1 0",
                     rx_ready, wr_data_q.size(), error, done);
        end
    endtask

    task automatic test_empty();
        apply_reset();
        frame_q = {8'h00, 8'h00, 8'h00};
        send_frame(0);
        vectors++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0 || wr_data_q.size() !== 0) begin
            miscompares++;
            $display("FAIL empty_ok: got done=%b error=%b cpu_reset=%b writes=%0d want 1 0 0 0",
                     done, error, cpu_reset, wr_data_q.size());
        end
        apply_reset();
        frame_q = {8'h00, 8'h00, 8'h01};
        send_frame(0);
        vectors++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_reset !== 1'b1 || wr_data_q.size() !== 0) begin
            miscompares++;
            $display("FAIL empty_bad: got done=%b error=%b cpu_reset=%b writes=%0d want 0 1 1 0",
                     done, error, cpu_reset, wr_data_q.size());
        end
    endtask

    task automatic test_oversize();
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] exp_word;
        int          bad;
        apply_reset();
        send_byte(8'h01);
        vectors++;
        if (error !== 1'b0) begin miscompares++; $display("FAIL over_early: got error=%b want 0", error); end
        send_byte(8'h01);
        vectors++;
        if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL over_err: got error=%b ready=%b cpu_reset=%b want 1 0 1", error, rx_ready, cpu_reset);
        end
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        repeat (6) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        vectors++;
        if (wr_data_q.size() !== 0) begin
            miscompares++;
            $display("FAIL over_writes: got %0d want 0", wr_data_q.size());
        end

        // Full-capacity image: 256 words.
        apply_reset();
        frame_q = {8'h01, 8'h00};
        cs = 8'h00;
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(k * 7 + j * 61 + 3);
                frame_q.push_back(b);
                cs = cs ^ b;
            end
        end
        frame_q.push_back(cs);
        send_frame(0);
        vectors++;
        if (wr_data_q.size() !== 256) begin
            miscompares++;
            $display("FAIL full_count: got %0d want 256", wr_data_q.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                exp_word = {8'(k * 7 + 3), 8'(k * 7 + 64), 8'(k * 7 + 125), 8'(k * 7 + 186)};
                if (wr_addr_q[k] !== 8'(k) || wr_data_q[k] !== exp_word) bad++;
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL full_contents: got %0d wrong words want 0", bad);
            end
            vectors++;
            if (wr_addr_q[255] !== 8'hFF) begin
                miscompares++;
                $display("FAIL full_last_addr: got %h want FF", wr_addr_q[255]);
            end
        end
        vectors++;
        if (done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: got done=%b error=%b want 1 0", done, error);
        end
    endtask

    task automatic test_stalled();
        apply_reset();
        set_nominal(8'h89);
        send_frame(3);
        vectors++;
        if (wr_data_q.size() !== 2) begin
            miscompares++;
            $display("FAIL stall_count: got %0d want 2", wr_data_q.size());
        end else begin
            vectors++;
            if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h20080005 ||
                wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'hAC080000) begin
                miscompares++;
                $display("FAIL stall_vals: got @%h %h @%h %h want @00 20080005 @01 AC080000",
                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
        vectors++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: got done=%b cpu_reset=%b error=%b want 1 0 0", done, cpu_reset, error);
        end
    endtask

    task automatic test_reset_midload();
        int low_seen;
        apply_reset();
        set_nominal(8'h89);
        low_seen = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(frame_q[i]);
            if (cpu_reset !== 1'b1) low_seen++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (cpu_reset !== 1'b1) low_seen++;
        vectors++;
        if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_vals: got we=%b @%h %h ready=%b want 0 @00 00000000 0",
                     imem_we, imem_addr, imem_wdata, rx_ready);
        end
        reset = 1'b0;
        wr_data_q.delete();
        wr_addr_q.delete();
        for (int i = 0; i < 11; i++) begin
            if (cpu_reset !== 1'b1) low_seen++;
            send_byte(frame_q[i]);
        end
        vectors++;
        if (low_seen !== 0) begin
            miscompares++;
            $display("FAIL mid_cpu_reset: got %0d low samples want 0", low_seen);
        end
        vectors++;
        if (wr_data_q.size() !== 2) begin
            miscompares++;
            $display("FAIL mid_count: got %0d want 2", wr_data_q.size());
        end else begin
            vectors++;
            if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h20080005 ||
                wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'hAC080000) begin
                miscompares++;
                $display("FAIL mid_vals: got @%h %h @%h %h want @00 20080005 @01 AC080000",
                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
        vectors++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_done: got done=%b cpu_reset=%b error=%b ready=%b want 1 0 0 0",
                     done, cpu_reset, error, rx_ready);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_empty();
        test_oversize();
        test_stalled();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
